// File: rtl/requantize_stream_pkg.sv
// Shared types and constant helpers for the streaming lane requantizer.
package requantize_stream_pkg;

  typedef enum logic {
    RND_FLOOR   = 1'b0,
    RND_HALF_UP = 1'b1
  } round_mode_e;

  // Internal width: room for the largest left shift plus a sign guard bit.
  function automatic int calc_w(input int in_width, input int shift_width);
    return in_width + (32'sd2 ** (shift_width - 32'sd1)) + 32'sd1;
  endfunction

  function automatic longint sat_max(input int out_width);
    return (64'sd1 <<< (out_width - 32'sd1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int out_width);
    return -(64'sd1 <<< (out_width - 32'sd1));
  endfunction

endpackage

// File: rtl/requantize_stream_if.sv
// Valid/ready stream bundle carrying packed input and output lane vectors.
interface requantize_stream_if #(
  parameter int IN_WIDTH  = 9,
  parameter int OUT_WIDTH = 8,
  parameter int SIZE      = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [IN_WIDTH*SIZE-1:0]  pixel_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [OUT_WIDTH*SIZE-1:0] pixel_out;
  logic [SIZE-1:0]           out_sat;

  modport master (
    output in_valid, pixel_in, out_ready,
    input  in_ready, out_valid, pixel_out, out_sat
  );

  modport slave (
    input  in_valid, pixel_in, out_ready,
    output in_ready, out_valid, pixel_out, out_sat
  );
endinterface

// File: rtl/requantize_lane.sv
// Combinational shift / optional round-half-up / saturate for one signed lane.
module requantize_lane
  import requantize_stream_pkg::*;
#(
  parameter int IN_WIDTH    = 9,
  parameter int OUT_WIDTH   = 8,
  parameter int SHIFT_WIDTH = 4
) (
  input  logic signed [IN_WIDTH-1:0]    i_x,
  input  logic signed [SHIFT_WIDTH-1:0] i_shift,
  input  round_mode_e                   i_round,
  output logic signed [OUT_WIDTH-1:0]   o_y,
  output logic                          o_sat
);
  localparam int W = calc_w(IN_WIDTH, SHIFT_WIDTH);
  localparam logic signed [W-1:0] MAX_V = W'(sat_max(OUT_WIDTH));
  localparam logic signed [W-1:0] MIN_V = W'(sat_min(OUT_WIDTH));

  logic signed [W-1:0]    w_x;
  logic signed [W-1:0]    w_bias;
  logic signed [W-1:0]    w_sum;
  logic signed [W-1:0]    w_y;
  logic [SHIFT_WIDTH:0]   w_k;
  logic [SHIFT_WIDTH-1:0] w_lamt;

  assign w_x    = {{(W-IN_WIDTH){i_x[IN_WIDTH-1]}}, i_x};
  // k = -shift, one bit wider so the most negative shift is representable
  assign w_k    = {(SHIFT_WIDTH+1){1'b0}} - {i_shift[SHIFT_WIDTH-1], i_shift};
  assign w_lamt = i_shift;
  assign w_bias = {{(W-1){1'b0}}, 1'b1} << (w_k - {{SHIFT_WIDTH{1'b0}}, 1'b1});
  assign w_sum  = w_x + w_bias;

  always_comb begin
    w_y = w_x;
    if (!i_shift[SHIFT_WIDTH-1]) begin
      w_y = w_x <<< w_lamt;
    end else if (i_round == RND_HALF_UP) begin
      w_y = w_sum >>> w_k;
    end else begin
      w_y = w_x >>> w_k;
    end
  end

  always_comb begin
    o_y   = w_y[OUT_WIDTH-1:0];
    o_sat = 1'b0;
    if (w_y > MAX_V) begin
      o_y   = MAX_V[OUT_WIDTH-1:0];
      o_sat = 1'b1;
    end else if (w_y < MIN_V) begin
      o_y   = MIN_V[OUT_WIDTH-1:0];
      o_sat = 1'b1;
    end else begin
      o_y   = w_y[OUT_WIDTH-1:0];
      o_sat = 1'b0;
    end
  end

endmodule

// File: rtl/requantize_stream.sv
// Two-stage valid/ready requantizer: stage 1 captures beat plus its config, stage 2 holds results.
module requantize_stream
  import requantize_stream_pkg::*;
#(
  parameter int IN_WIDTH    = 9,
  parameter int OUT_WIDTH   = 8,
  parameter int SIZE        = 4,
  parameter int SHIFT_WIDTH = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cfg_we,
  input  logic signed [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic                          cfg_round,
  input  logic                          sat_clear,
  output logic [CNT_WIDTH-1:0]          sat_count,
  requantize_stream_if.slave            s_if
);
  logic signed [SHIFT_WIDTH-1:0] r_shift;
  round_mode_e                   r_round;
  logic                          r_v1;
  logic [IN_WIDTH*SIZE-1:0]      r_x1;
  logic signed [SHIFT_WIDTH-1:0] r_shift1;
  round_mode_e                   r_round1;
  logic                          r_v2;
  logic [OUT_WIDTH*SIZE-1:0]     r_y2;
  logic [SIZE-1:0]               r_sat2;
  logic [CNT_WIDTH-1:0]          r_cnt;

  logic                      w_adv1;
  logic                      w_adv2;
  logic                      w_hs_sat;
  logic [OUT_WIDTH*SIZE-1:0] w_y;
  logic [SIZE-1:0]           w_sat;

  assign w_adv2   = !r_v2 || s_if.out_ready;
  assign w_adv1   = !r_v1 || w_adv2;
  assign w_hs_sat = r_v2 && s_if.out_ready && (|r_sat2);

  assign s_if.in_ready  = w_adv1;
  assign s_if.out_valid = r_v2;
  assign s_if.pixel_out = r_y2;
  assign s_if.out_sat   = r_sat2;
  assign sat_count      = r_cnt;

  for (genvar g = 0; g < SIZE; g++) begin : g_lane
    requantize_lane #(
      .IN_WIDTH    (IN_WIDTH),
      .OUT_WIDTH   (OUT_WIDTH),
      .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_lane (
      .i_x     (r_x1[IN_WIDTH*g +: IN_WIDTH]),
      .i_shift (r_shift1),
      .i_round (r_round1),
      .o_y     (w_y[OUT_WIDTH*g +: OUT_WIDTH]),
      .o_sat   (w_sat[g])
    );
  end

  // Runtime configuration; a beat accepted in the write cycle still sees the old values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shift <= {SHIFT_WIDTH{1'b0}};
      r_round <= RND_FLOOR;
    end else if (cfg_we) begin
      r_shift <= cfg_shift;
      r_round <= round_mode_e'(cfg_round);
    end
  end

  // Pipeline stages; data registers move only when their stage advances.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_v1     <= 1'b0;
      r_x1     <= {(IN_WIDTH*SIZE){1'b0}};
      r_shift1 <= {SHIFT_WIDTH{1'b0}};
      r_round1 <= RND_FLOOR;
      r_v2     <= 1'b0;
      r_y2     <= {(OUT_WIDTH*SIZE){1'b0}};
      r_sat2   <= {SIZE{1'b0}};
    end else begin
      if (w_adv1) begin
        r_v1 <= s_if.in_valid;
        if (s_if.in_valid) begin
          r_x1     <= s_if.pixel_in;
          r_shift1 <= r_shift;
          r_round1 <= r_round;
        end
      end
      if (w_adv2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_y2   <= w_y;
          r_sat2 <= w_sat;
        end
      end
    end
  end

  // Saturated-beat counter; clear wins over a same-cycle increment, and it sticks at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= {CNT_WIDTH{1'b0}};
    end else if (sat_clear) begin
      r_cnt <= {CNT_WIDTH{1'b0}};
    end else if (w_hs_sat && (r_cnt != {CNT_WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_requantize_stream.sv
// Scoreboard bench for requantize_stream: expected beats are queued at input handshake and checked at output.
module tb_requantize_stream;

  typedef struct {
    logic [31:0] pix;
    logic [3:0]  sat;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_we = 1'b0;
  logic signed [3:0] cfg_shift = 4'sd0;
  logic              cfg_round = 1'b0;
  logic              sat_clear = 1'b0;
  logic [15:0]       sat_count;

  requantize_stream_if #(.IN_WIDTH(9), .OUT_WIDTH(8), .SIZE(4)) s_if ();

  requantize_stream #(
    .IN_WIDTH(9), .OUT_WIDTH(8), .SIZE(4), .SHIFT_WIDTH(4), .CNT_WIDTH(16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_shift (cfg_shift),
    .cfg_round (cfg_round),
    .sat_clear (sat_clear),
    .sat_count (sat_count),
    .s_if      (s_if)
  );

  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  exp_t sb[$];
  int   m_shift = 0;
  bit   m_round = 1'b0;
  int   m_cnt   = 0;

  // Independent reference: integer arithmetic with floor division, then clamp.
  function automatic exp_t model(input logic [35:0] px, input int s, input bit rnd);
    exp_t   e;
    longint x, d, n, v;
    for (int i = 0; i < 4; i++) begin
      x = longint'($signed(px[9*i +: 9]));
      if (s > 0) begin
        v = x * (64'sd1 << s);
      end else if (s < 0) begin
        d = 64'sd1 << (-s);
        n = rnd ? x + d / 2 : x;
        v = n / d;
        if (n < 0 && (n % d) != 0) v = v - 1;
      end else begin
        v = x;
      end
      if (v > 127) begin
        e.pix[8*i +: 8] = 8'h7F; e.sat[i] = 1'b1;
      end else if (v < -128) begin
        e.pix[8*i +: 8] = 8'h80; e.sat[i] = 1'b1;
      end else begin
        e.pix[8*i +: 8] = v[7:0]; e.sat[i] = 1'b0;
      end
    end
    return e;
  endfunction

  // Monitor: pop/compare delivered beats, push accepted beats, track config and counter model.
  always @(negedge clock) begin
    exp_t e;
    bit   hs_sat;
    if (reset) begin
      sb.delete();
      m_shift = 0;
      m_round = 1'b0;
      m_cnt   = 0;
    end else begin
      hs_sat = 1'b0;
      if (s_if.out_valid && s_if.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: pixel_out=%h out_sat=%b, required no beat", s_if.pixel_out, s_if.out_sat);
        end else begin
          e = sb.pop_front();
          n_out++;
          hs_sat = |e.sat;
          if (s_if.pixel_out !== e.pix || s_if.out_sat !== e.sat) begin
            errors++;
            $display("FAIL beat %0d: pixel_out=%h out_sat=%b, required pixel_out=%h out_sat=%b",
                     n_out, s_if.pixel_out, s_if.out_sat, e.pix, e.sat);
          end
        end
      end
      if (sat_clear) m_cnt = 0;
      else if (hs_sat && m_cnt != 65535) m_cnt++;
      if (s_if.in_valid && s_if.in_ready) sb.push_back(model(s_if.pixel_in, m_shift, m_round));
      if (cfg_we) begin
        m_shift = int'(cfg_shift);
        m_round = cfg_round;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cfg(input int s, input bit r);
    cfg_shift = s[3:0];
    cfg_round = r;
    cfg_we    = 1'b1;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic send(input logic [35:0] px);
    bit acc = 1'b0;
    int n = 0;
    s_if.in_valid = 1'b1;
    s_if.pixel_in = px;
    while (!acc && n < 50) begin
      @(negedge clock);
      acc = s_if.in_ready;
      tick();
      n++;
    end
    s_if.in_valid = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic drain();
    int n = 0;
    s_if.out_ready = 1'b1;
    while (sb.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    s_if.in_valid  = 1'b0;
    s_if.pixel_in  = 36'd0;
    s_if.out_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (s_if.out_valid !== 1'b0 || s_if.pixel_out !== 32'd0 || s_if.out_sat !== 4'd0 || sat_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b pixel_out=%h out_sat=%b sat_count=%0d, required 0 0 0 0",
               s_if.out_valid, s_if.pixel_out, s_if.out_sat, sat_count);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (s_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: in_ready=%b, required 1", s_if.in_ready);
    end
    tick();
  endtask

  task automatic test_default_latency();
    send({9'h1FF, 9'd5, 9'h100, 9'd255});
    @(negedge clock);
    checks++;
    if (s_if.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid=%b one cycle after accept, required 0", s_if.out_valid);
    end
    @(negedge clock);
    checks++;
    if (s_if.out_valid !== 1'b1 || s_if.pixel_out !== 32'hFF05807F || s_if.out_sat !== 4'b0011) begin
      errors++;
      $display("FAIL default_beat: out_valid=%b pixel_out=%h out_sat=%b, required 1 ff05807f 0011",
               s_if.out_valid, s_if.pixel_out, s_if.out_sat);
    end
    tick();
    @(negedge clock);
    checks++;
    if (sat_count !== 16'd1) begin
      errors++;
      $display("FAIL default_sat_count: sat_count=%0d, required 1", sat_count);
    end
    tick();
  endtask

  task automatic test_shift_round();
    set_cfg(-1, 1'b0);
    send({9'h1FD, 9'h1FD, 9'd101, 9'd100});
    set_cfg(-1, 1'b1);
    send({9'h1FD, 9'h1FD, 9'd101, 9'd100});
    set_cfg(2, 1'b0);
    send({9'h1DF, 9'd31, 9'h1EC, 9'd40});
    set_cfg(-8, 1'b1);
    send({9'd0, 9'd0, 9'd0, 9'd255});
    set_cfg(-8, 1'b0);
    send({9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF});
    drain();
    @(negedge clock);
    checks++;
    if (sat_count !== 16'(m_cnt)) begin
      errors++;
      $display("FAIL shift_sat_count: sat_count=%0d, required %0d", sat_count, m_cnt);
    end
    tick();
  endtask

  task automatic test_stream();
    logic [35:0] beats [10];
    logic [31:0] held_pix;
    logic [3:0]  held_sat;
    bit          stalled = 1'b0;
    bit          acc;
    int          sent = 0;
    int          c = 0;
    int          base = n_out;
    for (int i = 0; i < 10; i++) beats[i] = {$urandom(), $urandom()};
    set_cfg(0, 1'b0);
    while (sent < 10 && c < 100) begin
      s_if.in_valid  = 1'b1;
      s_if.pixel_in  = beats[sent];
      s_if.out_ready = (c < 4 || c > 6);
      cfg_we    = (c == 5);
      cfg_shift = -4'sd2;
      cfg_round = 1'b1;
      @(negedge clock);
      if (stalled) begin
        checks++;
        if (s_if.out_valid !== 1'b1 || s_if.pixel_out !== held_pix || s_if.out_sat !== held_sat) begin
          errors++;
          $display("FAIL stall_hold: out_valid=%b pixel_out=%h out_sat=%b, required 1 %h %b",
                   s_if.out_valid, s_if.pixel_out, s_if.out_sat, held_pix, held_sat);
        end
      end
      if (!s_if.out_ready) begin
        checks++;
        if (s_if.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready: in_ready=%b during full stall, required 0", s_if.in_ready);
        end
      end
      acc      = s_if.in_ready;
      stalled  = s_if.out_valid && !s_if.out_ready;
      held_pix = s_if.pixel_out;
      held_sat = s_if.out_sat;
      tick();
      if (acc) sent++;
      c++;
    end
    s_if.in_valid = 1'b0;
    cfg_we = 1'b0;
    drain();
    @(negedge clock);
    checks++;
    if (n_out - base !== 10 || sat_count !== 16'(m_cnt)) begin
      errors++;
      $display("FAIL stream_count: delivered=%0d sat_count=%0d, required 10 %0d", n_out - base, sat_count, m_cnt);
    end
    tick();
  endtask

  task automatic test_reset_midstream();
    set_cfg(1, 1'b1);
    s_if.out_ready = 1'b0;
    s_if.in_valid  = 1'b1;
    s_if.pixel_in  = {9'd100, 9'd100, 9'd100, 9'd100};
    tick();
    tick();
    s_if.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (s_if.out_valid !== 1'b0 || sat_count !== 16'd0 || s_if.pixel_out !== 32'd0) begin
      errors++;
      $display("FAIL midstream_reset: out_valid=%b sat_count=%0d pixel_out=%h, required 0 0 0",
               s_if.out_valid, sat_count, s_if.pixel_out);
    end
    tick();
    reset = 1'b0;
    s_if.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      checks++;
      if (s_if.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_beat: out_valid=%b in cycle %0d after reset, required 0", s_if.out_valid, i);
      end
      tick();
    end
    send({9'd3, 9'h1FE, 9'd7, 9'd64});
    drain();
  endtask

  task automatic test_counter();
    int acc_n = 0;
    int n = 0;
    set_cfg(0, 1'b0);
    sat_clear = 1'b1;
    tick();
    sat_clear = 1'b0;
    s_if.out_ready = 1'b1;
    s_if.in_valid  = 1'b1;
    s_if.pixel_in  = {9'd0, 9'd0, 9'd0, 9'd255};
    while (acc_n < 65539 && n < 70000) begin
      @(negedge clock);
      if (s_if.in_ready) acc_n++;
      tick();
      n++;
    end
    s_if.in_valid = 1'b0;
    checks++;
    if (acc_n != 65539) begin
      errors++;
      $display("FAIL counter_feed: accepted=%0d, required 65539", acc_n);
    end
    drain();
    @(negedge clock);
    checks++;
    if (sat_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL counter_stick: sat_count=%h, required ffff", sat_count);
    end
    tick();
    send({9'd0, 9'd0, 9'd0, 9'd255});
    tick();
    sat_clear = 1'b1;
    @(negedge clock);
    checks++;
    if (s_if.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL clear_align: out_valid=%b, required 1", s_if.out_valid);
    end
    tick();
    sat_clear = 1'b0;
    @(negedge clock);
    checks++;
    if (sat_count !== 16'd0) begin
      errors++;
      $display("FAIL clear_priority: sat_count=%0d, required 0", sat_count);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_default_latency();
    test_shift_round();
    test_stream();
    test_reset_midstream();
    test_counter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/requantize_stream.md
# requantize_stream

Parametrised, streaming successor to the fixed 9-to-8-bit requantizer. Converts a vector of SIZE signed lanes from IN_WIDTH to OUT_WIDTH bits. The conversion applies a runtime-programmable arithmetic shift, optional round-half-up on right shifts, and saturation with per-lane overflow flags. It sits between a layer accumulator/adder stage and the next layer's input buffer, with valid/ready flow control and a saturation event counter for quantisation tuning.

## Interface
- IN_WIDTH, 9, signed input lane width (≥ 2)
- OUT_WIDTH, 8, signed output lane width (2 ≤ OUT_WIDTH ≤ IN_WIDTH + 2^(SHIFT_WIDTH-1))
- SIZE, 4, number of lanes
- SHIFT_WIDTH, 4, width of signed shift field; range −2^(SHIFT_WIDTH-1) … 2^(SHIFT_WIDTH-1)−1
- CNT_WIDTH, 16, saturation counter width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- cfg_we  in  1  load cfg_shift/cfg_round into config registers
- cfg_shift  in  SHIFT_WIDTH  signed shift; >0 left, <0 arithmetic right by −shift
- cfg_round  in  1  1 = round-half-up on right shifts, 0 = floor
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- pixel_in  in  IN_WIDTH*SIZE  lane i at [IN_WIDTH*i +: IN_WIDTH]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- pixel_out  out  OUT_WIDTH*SIZE  lane i at [OUT_WIDTH*i +: OUT_WIDTH]
- out_sat  out  SIZE  per-lane saturation flag, aligned with pixel_out
- sat_clear  in  1  synchronous clear of sat_count
- sat_count  out  CNT_WIDTH  beats delivered with ≥1 saturated lane; sticks at all-ones

## Operation
- Config registers: shift_r, round_r. Reset values are 0 and 0. Loaded on cfg_we. A beat accepted in the same cycle as cfg_we uses the old values; beats accepted later use the new values. Each beat carries its own shift/round down the pipe, so in-flight beats are unaffected by config writes.
- Stage 1 (shift/round): extend the lane to W = IN_WIDTH + 2^(SHIFT_WIDTH-1) + 1 bits.
  - s > 0: x <<< s.
  - s < 0, round_r = 1: (x + 2^(k−1)) >>> k, where k = −s.
  - s < 0, round_r = 0: x >>> k.
  - s = 0: x unchanged.
  - Right shifts ≥ IN_WIDTH yield 0 or −1 (floor); with rounding, the add is done in W bits, so the result is correct.
- Stage 2 (saturate): if the W-bit value exceeds 2^(OUT_WIDTH−1)−1, output the max and set out_sat[i]. If it is below −2^(OUT_WIDTH−1), output the min and set out_sat[i]. Otherwise output the low OUT_WIDTH bits and clear out_sat[i].
- Counter: increments on the output handshake (out_valid & out_ready & |out_sat), saturating at all-ones. sat_clear has priority over the increment in the same cycle.

## Timing
- Two-stage pipeline with valid bits v1, v2. Latency is 2 cycles from input handshake to out_valid when there is no stall.
- adv2 = !v2 | out_ready; adv1 = !v1 | adv2; in_ready = adv1 (combinational from out_ready; no skid).
- Full throughput: 1 beat/cycle while out_ready = 1.
- While out_ready = 0 and both stages are full: in_ready = 0, and pixel_out/out_sat/out_valid are held stable.
- A beat is never dropped or duplicated. Data registers load only on advance.
- Reset (async, any time, including mid-stream):
  - v1, v2, out_valid → 0.
  - pixel_out, out_sat → 0.
  - sat_count → 0.
  - shift_r, round_r → 0.
  - In-flight beats are discarded.
  - in_ready = 1 in the first cycle after reset deasserts.

## Structure
- Shared package: round-mode encoding, W width function, saturation min/max constant functions.
- One sub-module, requantize_lane: combinational shift/round/saturate for a single lane, instantiated SIZE times.
- Pipeline registers and control stay in the top module.

## Test plan
- Defaults, shift 0: lanes 255, −256, 5, −1 → 127 (sat), −128 (sat), 5, −1. out_sat = 4'b0011, sat_count = 1 after the handshake.
- Shift −1: lanes 100, 101, −3, −3. With round 0 → 50, 50, −2, −2. With round 1 → 50, 51, −1, −1. No saturation.
- Shift +2: lanes 40, −20, 31, −33 → 127 (sat), −80, 124, −128 (sat). Shift −8, round 1, lane 255 → 1. Shift −8, round 0, lane −1 → −1.
- Stream 10 beats with out_ready low for 3 cycles mid-stream: all 10 beats are delivered in order, unchanged, and outputs are stable during the stall. cfg_we issued mid-stream affects only beats accepted after the write cycle.
- Reset asserted while 2 beats are in flight: out_valid drops immediately and sat_count = 0. No stale beat appears after reset release.
- Counter: force 2^CNT_WIDTH + 3 saturating beats → sat_count holds all-ones. sat_clear together with a saturating handshake → 0.
